axis_read_burst: RTL and testbench
==================================

AXIS_READ_BURST -- requirements
Module: axis_read_burst

Interface
REQ-001 Parameters SHALL be: CFG_AWIDTH, default 32, cfg_address width; CFG_DWIDTH, default 32, cfg_length width; WIDTH_RATIO, default 2, stream words per AXI beat (power of 2); AXI_ADDR_WIDTH, default 32; AXI_DATA_WIDTH, default 64; AXI_LEN_WIDTH, default 8; BURST_MAX, default 16, max beats per burst; OUTSTANDING, default 4, max open bursts.
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 cfg_address  input  CFG_AWIDTH  stream byte start address.
REQ-005 cfg_length  input  CFG_DWIDTH  stream length in stream words.
REQ-006 cfg_valid / cfg_ready  input / output  1 each  config handshake.
REQ-007 axi_araddr  output  AXI_ADDR_WIDTH  burst address.
REQ-008 axi_arlen  output  AXI_LEN_WIDTH  beats minus one.
REQ-009 axi_arsize / axi_arburst  output  3 / 2  constant log2(AXI_DATA_WIDTH/8) / INCR (2'b01).
REQ-010 axi_arvalid / axi_arready  output / input  1 each  AR handshake.
REQ-011 axi_rvalid, axi_rready, axi_rlast  input  1 each  monitored R channel, for burst completion only.
REQ-012 busy  output  1  high whenever not in CONFIG.

Function
REQ-013 States SHALL be one-hot: CONFIG, SETUP, ISSUE, DRAIN.
REQ-014 CONFIG: cfg_ready=1; on cfg_valid latch address (low log2(AXI_DATA_WIDTH/8) bits forced 0) and beats = ceil(cfg_length/WIDTH_RATIO); go SETUP.
REQ-015 SETUP (one cycle): beats==0 -> CONFIG, no AR issued; else compute first burst -> ISSUE.
REQ-016 Burst size SHALL be min(remaining beats, BURST_MAX, beats to next 4 KB boundary when REQ-026 applies); axi_arlen = size-1.
REQ-017 axi_arvalid SHALL be registered; asserted only in ISSUE when open-burst count < OUTSTANDING.
REQ-018 While axi_arvalid=1 and axi_arready=0, axi_araddr and axi_arlen SHALL hold stable; axi_arvalid SHALL NOT drop.
REQ-019 On AR handshake: address += size*(AXI_DATA_WIDTH/8); remaining -= size; next burst's axi_arvalid no earlier than the following cycle; open count +1.
REQ-020 Last AR handshake (remaining reaches 0) -> DRAIN.
REQ-021 Open count -1 on axi_rvalid & axi_rready & axi_rlast; simultaneous inc and dec SHALL leave count unchanged; count SHALL never exceed OUTSTANDING nor go below 0.
REQ-022 DRAIN: stay until open count == 0, then CONFIG (cfg_ready=1 next cycle).
REQ-023 Address arithmetic SHALL wrap modulo 2^AXI_ADDR_WIDTH; remaining count SHALL be CFG_DWIDTH bits wide.

Reset
REQ-024 rst low SHALL asynchronously force: state CONFIG, cfg_ready=1, axi_arvalid=0, axi_araddr=0, axi_arlen=0, open count 0, busy=0; axi_arsize/axi_arburst stay at their constants.
REQ-025 Reset mid-transfer SHALL abandon all pending bursts; no AR issued after release until new cfg handshake.

Configuration
REQ-026 Macro AXIS_READ_4K_SPLIT_EN: defined -> bursts SHALL never cross a 4 KB address boundary (extra split per REQ-016); undefined -> limit omitted, bursts limited by BURST_MAX and remaining only.

Verification
REQ-027 cfg_address 0x1000, cfg_length 8, arready=1 -> one AR: araddr 0x1000, arlen 3; one rlast -> cfg_ready=1.
REQ-028 cfg_address 0x0, cfg_length 80 -> ARs 0x000/arlen 15, 0x080/15, 0x100/7; odd cfg_length 7 -> single arlen 3.
REQ-029 cfg_address 0x0FC0, cfg_length 32: with macro -> 0x0FC0/arlen 7 then 0x1000/arlen 7; without -> 0x0FC0/arlen 15.
REQ-030 arready low 5 cycles while arvalid=1 -> arvalid, araddr, arlen unchanged all 5 cycles.
REQ-031 cfg_length 160 (5 bursts), no rlast -> exactly 4 ARs then arvalid=0; one rlast -> 5th AR issued; rlast coincident with AR handshake -> count stays 4.
REQ-032 cfg_length 0 -> no AR, cfg_ready=1 two cycles after cfg handshake; rst pulsed low during ISSUE -> arvalid=0 immediately, cfg_ready=1 with no further ARs.

Source files
------------

// File: rtl/axis_read_burst.sv
// AXI read-address burst generator: turns a (byte address, stream-word length) request into AR bursts.
// Optional 4 KB boundary splitting is enabled by defining AXIS_READ_4K_SPLIT_EN.
module axis_read_burst #(
  parameter int CFG_AWIDTH     = 32,
  parameter int CFG_DWIDTH     = 32,
  parameter int WIDTH_RATIO    = 2,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_LEN_WIDTH  = 8,
  parameter int BURST_MAX      = 16,
  parameter int OUTSTANDING    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CFG_AWIDTH-1:0]     cfg_address,
  input  logic [CFG_DWIDTH-1:0]     cfg_length,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  output logic [AXI_ADDR_WIDTH-1:0] axi_araddr,
  output logic [AXI_LEN_WIDTH-1:0]  axi_arlen,
  output logic [2:0]                axi_arsize,
  output logic [1:0]                axi_arburst,
  output logic                      axi_arvalid,
  input  logic                      axi_arready,
  input  logic                      axi_rvalid,
  input  logic                      axi_rready,
  input  logic                      axi_rlast,
  output logic                      busy
);

  localparam int BPB = AXI_DATA_WIDTH / 8;
  localparam int ASZ = $clog2(BPB);
  localparam int RSH = $clog2(WIDTH_RATIO);
  localparam int SW  = (CFG_DWIDTH > 14) ? CFG_DWIDTH : 14;
  localparam int OW  = $clog2(OUTSTANDING + 1);

  typedef enum logic [3:0] {
    CONFIG = 4'b0001,
    SETUP  = 4'b0010,
    ISSUE  = 4'b0100,
    DRAIN  = 4'b1000
  } state_t;

  state_t                    state_reg, state_next;
  logic [AXI_ADDR_WIDTH-1:0] addr_reg;
  logic [CFG_DWIDTH-1:0]     remaining_reg;
  logic [CFG_DWIDTH-1:0]     size_reg;
  logic [OW-1:0]             open_cnt_reg;
  logic [CFG_DWIDTH-1:0]     beats_in;
  logic [AXI_ADDR_WIDTH-1:0] addr_in;
  logic [SW-1:0]             size_w;
  logic                      ar_hs;
  logic                      r_done;

  assign axi_arsize  = 3'(ASZ);
  assign axi_arburst = 2'b01;
  assign ar_hs       = axi_arvalid & axi_arready;
  assign r_done      = axi_rvalid & axi_rready & axi_rlast;
  assign addr_in     = AXI_ADDR_WIDTH'(cfg_address) & ~AXI_ADDR_WIDTH'(BPB - 1);

  // Round up to whole AXI beats without risking overflow of cfg_length + ratio - 1.
  if (RSH == 0) begin : g_ratio_one
    assign beats_in = cfg_length;
  end else begin : g_ratio_many
    assign beats_in = (cfg_length >> RSH) + CFG_DWIDTH'(|cfg_length[RSH-1:0]);
  end

`ifdef AXIS_READ_4K_SPLIT_EN
  logic [SW-1:0] to_4k;
  assign to_4k = (SW'(4096) - SW'(addr_reg[11:0])) >> ASZ;
`endif

  always_comb begin
    size_w = SW'(remaining_reg);
    if (size_w > SW'(BURST_MAX)) size_w = SW'(BURST_MAX);
`ifdef AXIS_READ_4K_SPLIT_EN
    if (size_w > to_4k) size_w = to_4k;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= CONFIG;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    cfg_ready  = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      CONFIG: begin
        cfg_ready = 1'b1;
        busy      = 1'b0;
        if (cfg_valid) state_next = SETUP;
      end
      SETUP: begin
        if (remaining_reg == '0) state_next = CONFIG;
        else                     state_next = ISSUE;
      end
      ISSUE: begin
        if (ar_hs && (remaining_reg == size_reg)) state_next = DRAIN;
      end
      DRAIN: begin
        if (open_cnt_reg == '0) state_next = CONFIG;
      end
      default: state_next = CONFIG;
    endcase
  end

  // AR channel and bookkeeping. arvalid drops on every handshake, so each
  // burst is computed from the already-advanced address and remaining count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_reg      <= '0;
      remaining_reg <= '0;
      size_reg      <= '0;
      open_cnt_reg  <= '0;
      axi_arvalid   <= 1'b0;
      axi_araddr    <= '0;
      axi_arlen     <= '0;
    end else begin
      if (state_reg == CONFIG && cfg_valid) begin
        addr_reg      <= addr_in;
        remaining_reg <= beats_in;
      end

      if (ar_hs) begin
        axi_arvalid   <= 1'b0;
        addr_reg      <= addr_reg + (AXI_ADDR_WIDTH'(size_reg) << ASZ);
        remaining_reg <= remaining_reg - size_reg;
      end else if (state_reg == ISSUE && !axi_arvalid &&
                   open_cnt_reg < OW'(OUTSTANDING)) begin
        axi_arvalid <= 1'b1;
        axi_araddr  <= addr_reg;
        axi_arlen   <= AXI_LEN_WIDTH'(size_w - SW'(1));
        size_reg    <= CFG_DWIDTH'(size_w);
      end

      case ({ar_hs, r_done})
        2'b10:   open_cnt_reg <= open_cnt_reg + OW'(1);
        2'b01:   if (open_cnt_reg != '0) open_cnt_reg <= open_cnt_reg - OW'(1);
        default: open_cnt_reg <= open_cnt_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_read_burst.sv
// Randomised self-checking bench for axis_read_burst; expected AR bursts come from an
// arithmetic burst-splitting model (honours AXIS_READ_4K_SPLIT_EN like the design).
module tb_axis_read_burst;

  localparam int WR = 2;

  logic        clk;
  logic        rst;
  logic [31:0] cfg_address;
  logic [31:0] cfg_length;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;
  logic        axi_arvalid;
  logic        axi_arready;
  logic        axi_rvalid;
  logic        axi_rready;
  logic        axi_rlast;
  logic        busy;

  int n_err;
  int n_checks;

  logic [31:0] ar_log_addr[$];
  logic [7:0]  ar_log_len[$];
  longint      exp_a[$];
  longint      exp_l[$];

  int r_count;
  int man_req;
  int man_done;
  bit resp_en;
  bit ar_mode;
  bit ar_fixed;

  axis_read_burst dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_address (cfg_address),
    .cfg_length  (cfg_length),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .axi_araddr  (axi_araddr),
    .axi_arlen   (axi_arlen),
    .axi_arsize  (axi_arsize),
    .axi_arburst (axi_arburst),
    .axi_arvalid (axi_arvalid),
    .axi_arready (axi_arready),
    .axi_rvalid  (axi_rvalid),
    .axi_rready  (axi_rready),
    .axi_rlast   (axi_rlast),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs only change shortly after a rising edge, so a negedge sample predicts the next handshake.
  always @(negedge clk) begin
    if (rst && axi_arvalid && axi_arready) begin
      ar_log_addr.push_back(axi_araddr);
      ar_log_len.push_back(axi_arlen);
    end
  end

  // R-channel responder plus arready driver; runs after the main process each cycle.
  always begin
    logic        pulse;
    int unsigned nz;
    @(posedge clk);
    #2;
    axi_arready = ar_mode ? 1'($urandom_range(0, 1)) : ar_fixed;
    pulse = 1'b0;
    if (man_req != man_done) begin
      pulse = 1'b1;
      man_done++;
    end else if (resp_en && ar_log_addr.size() > r_count && $urandom_range(0, 2) == 0) begin
      pulse = 1'b1;
    end
    if (pulse) r_count++;
    nz = resp_en ? $urandom_range(0, 3) : 0;
    if (pulse) begin
      axi_rvalid = 1'b1; axi_rready = 1'b1; axi_rlast = 1'b1;
    end else begin
      axi_rvalid = (nz == 1) || (nz == 2);
      axi_rready = (nz == 1) || (nz == 3);
      axi_rlast  = (nz == 2) || (nz == 3);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_bursts(input longint a, input longint l);
    longint beats, n, lim;
    exp_a.delete();
    exp_l.delete();
    beats = (l + WR - 1) / WR;
    a = a & 64'hFFFF_FFF8;
    while (beats > 0) begin
      n = (beats < 16) ? beats : 16;
`ifdef AXIS_READ_4K_SPLIT_EN
      lim = (4096 - (a % 4096)) / 8;
      if (n > lim) n = lim;
`else
      lim = n;
`endif
      exp_a.push_back(a);
      exp_l.push_back(n - 1);
      a = (a + n * 8) % 64'h1_0000_0000;
      beats -= n;
    end
  endtask

  task automatic start_cfg(input logic [31:0] a, input logic [31:0] l);
    @(posedge clk); #1;
    cfg_address = a;
    cfg_length  = l;
    cfg_valid   = 1'b1;
    @(negedge clk);
    check("cfg_ready_idle", cfg_ready, 1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (cfg_ready) break;
    end
    if (!cfg_ready) check("timeout_idle", 0, 1);
  endtask

  task automatic wait_arvalid();
    int k;
    k = 0;
    while (k < 200 && !axi_arvalid) begin
      @(negedge clk);
      k++;
    end
    if (!axi_arvalid) check("timeout_arvalid", 0, 1);
  endtask

  task automatic compare_ars(input string tag, input int start, input longint a, input longint l);
    int got_n;
    model_bursts(a, l);
    got_n = ar_log_addr.size() - start;
    check({tag, "_count"}, got_n, exp_a.size());
    for (int i = 0; i < exp_a.size() && i < got_n; i++) begin
      check({tag, "_addr"}, ar_log_addr[start + i], exp_a[i]);
      check({tag, "_len"}, ar_log_len[start + i], exp_l[i]);
    end
    $display("xfer %s addr=0x%08h len=%0d bursts=%0d", tag, a[31:0], l, got_n);
  endtask

  task automatic run_xfer(input string tag, input logic [31:0] a, input logic [31:0] l);
    int start, cyc;
    start = ar_log_addr.size();
    start_cfg(a, l);
    wait_idle(cyc);
    compare_ars(tag, start, a, l);
    if (l == 0) check({tag, "_ready_delay"}, cyc, 2);
  endtask

  initial begin
    int start;
    n_err = 0; n_checks = 0;
    r_count = 0; man_req = 0; man_done = 0;
    resp_en = 1'b0; ar_mode = 1'b0; ar_fixed = 1'b1;
    rst = 1'b0;
    cfg_valid = 1'b0; cfg_address = '0; cfg_length = '0;
    axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rready = 1'b0; axi_rlast = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_arvalid", axi_arvalid, 0);
    check("rst_araddr", axi_araddr, 0);
    check("rst_arlen", axi_arlen, 0);
    check("rst_busy", busy, 0);
    check("rst_arsize", axi_arsize, 3);
    check("rst_arburst", axi_arburst, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    resp_en = 1'b1;

    run_xfer("single", 32'h1000, 8);
    run_xfer("len80", 32'h0, 80);
    run_xfer("odd7", 32'h0, 7);
    run_xfer("cross4k", 32'h0FC0, 32);
    run_xfer("wrap", 32'hFFFF_FFC0, 40);
    run_xfer("unaligned", 32'h0000_0FFD, 3);
    run_xfer("zero", 32'h2004, 0);

    for (int i = 0; i < 10; i++) begin
      ar_mode = 1'($urandom_range(0, 1));
      run_xfer("rand", $urandom_range(0, 32'h3FFF), $urandom_range(0, 300));
    end
    ar_mode = 1'b0;

    // arready held low: the pending AR must stay put
    ar_fixed = 1'b0;
    start = ar_log_addr.size();
    start_cfg(32'h2000, 32);
    wait_arvalid();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_arvalid", axi_arvalid, 1);
      check("stall_araddr", axi_araddr, 32'h2000);
      check("stall_arlen", axi_arlen, 15);
    end
    ar_fixed = 1'b1;
    begin
      int cyc;
      wait_idle(cyc);
    end
    compare_ars("stall", start, 32'h2000, 32);

    // outstanding limit, then rlast coincident with an AR handshake
    resp_en = 1'b0;
    start = ar_log_addr.size();
    start_cfg(32'h0, 200);
    repeat (40) @(negedge clk);
    check("limit_ars", ar_log_addr.size() - start, 4);
    check("limit_arvalid", axi_arvalid, 0);
    @(posedge clk); #1;
    ar_fixed = 1'b0;
    man_req++;
    wait_arvalid();
    check("after_rlast_ars", ar_log_addr.size() - start, 4);
    @(posedge clk); #1;
    ar_fixed = 1'b1;
    man_req++;
    repeat (40) @(negedge clk);
    check("coincident_ars", ar_log_addr.size() - start, 6);
    check("coincident_arvalid", axi_arvalid, 0);
    resp_en = 1'b1;
    begin
      int cyc;
      wait_idle(cyc);
    end
    compare_ars("outstanding", start, 32'h0, 200);

    // reset while an AR is pending
    resp_en = 1'b0;
    ar_fixed = 1'b0;
    start_cfg(32'h0, 200);
    wait_arvalid();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("arst_arvalid", axi_arvalid, 0);
    check("arst_cfg_ready", cfg_ready, 1);
    check("arst_busy", busy, 0);
    check("arst_araddr", axi_araddr, 0);
    start = ar_log_addr.size();
    @(posedge clk); #1;
    rst = 1'b1;
    ar_fixed = 1'b1;
    repeat (30) @(negedge clk);
    check("post_rst_ars", ar_log_addr.size() - start, 0);
    check("post_rst_ready", cfg_ready, 1);
    check("post_rst_arvalid", axi_arvalid, 0);
    resp_en = 1'b1;
    run_xfer("recover", 32'h1000, 8);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
